download_mapper: RTL and testbench



---
 rtl/download_mapper_pkg.sv | 20 ++
 rtl/download_mapper_index_matcher.sv | 36 +++
 rtl/download_mapper.sv | 157 +++++++++++++++
 tb/tb_download_mapper.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/download_mapper_pkg.sv
// Shared types and default constants for the download mapper: FSM states,
// data_io index codes and the default memory map of the program region.
package download_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PATCH  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [7:0]  IDX_ROM        = 8'h00;
    localparam logic [7:0]  IDX_PRG        = 8'h01;
    localparam logic [7:0]  IDX_PRG_ALT    = 8'h41;

    localparam logic [24:0] PRG_BASE       = 25'h10995;
    localparam logic [24:0] DEF_PATCH_ADDR = 25'h103E9;
    localparam logic [31:0] DEF_PTR_BASE   = 32'h8995;

endpackage

// File: rtl/download_mapper_index_matcher.sv
// Combinational match/mask table lookup of a data_io index; the lowest
// matching entry wins and a zero mask disables an entry.
module index_matcher #(
    parameter int                       ADDR_W    = 25,
    parameter int                       NREG      = 4,
    parameter int                       ENT_W     = 2,
    parameter logic [NREG*8-1:0]        IDX_MATCH = '0,
    parameter logic [NREG*8-1:0]        IDX_MASK  = '0,
    parameter logic [NREG*ADDR_W-1:0]   REG_BASE  = '0,
    parameter logic [NREG-1:0]          REG_PATCH = '0
) (
    input  logic [7:0]        index,
    output logic              hit,
    output logic [ENT_W-1:0]  entry,
    output logic [ADDR_W-1:0] base,
    output logic              patch
);

    always_comb begin
        hit   = 1'b0;
        entry = '0;
        base  = '0;
        patch = 1'b0;
        // Walk from the top so the lowest matching entry is written last.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (IDX_MASK[8*i +: 8] != 8'h00 &&
                ((index ^ IDX_MATCH[8*i +: 8]) & IDX_MASK[8*i +: 8]) == 8'h00) begin
                hit   = 1'b1;
                entry = i[ENT_W-1:0];
                base  = REG_BASE[ADDR_W*i +: ADDR_W];
                patch = REG_PATCH[i];
            end
        end
    end

endmodule

// File: rtl/download_mapper.sv
// Routes the data_io byte stream into a per-index memory region and, when the
// region asks for it, writes back an end-of-program pointer paced by mem_ack.
module download_mapper
    import download_pkg::*;
#(
    parameter int                     ADDR_W     = 25,
    parameter int                     NREG       = 4,
    parameter logic [NREG*8-1:0]      IDX_MATCH  = {8'h00, IDX_ROM, IDX_PRG_ALT, IDX_PRG},
    parameter logic [NREG*8-1:0]      IDX_MASK   = {8'h00, 8'hFF, 8'hFF, 8'hFF},
    parameter logic [NREG*ADDR_W-1:0] REG_BASE   = {25'h0, 25'h0, PRG_BASE, PRG_BASE},
    parameter logic [NREG-1:0]        REG_PATCH  = 4'b0011,
    parameter logic [ADDR_W-1:0]      PATCH_ADDR = DEF_PATCH_ADDR,
    parameter logic [31:0]            PTR_BASE   = DEF_PTR_BASE,
    parameter int                     PTR_BYTES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              mem_ack,
    output logic              downloading,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic [ADDR_W-1:0] length,
    output logic              unmapped,
    output logic              done
);

    localparam int ENT_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t              state, state_n;
    logic                dl_q, rise, fall, start, in_stream;
    logic                hit, patch, hit_q, patch_q, cur_hit;
    logic [ENT_W-1:0]    entry, ent_q;
    logic [ADDR_W-1:0]   base, base_q, cur_base, end_addr;
    logic                gap, k_last;
    logic [1:0]          k;
    logic [31:0]         ptr;

    index_matcher #(
        .ADDR_W    (ADDR_W),
        .NREG      (NREG),
        .ENT_W     (ENT_W),
        .IDX_MATCH (IDX_MATCH),
        .IDX_MASK  (IDX_MASK),
        .REG_BASE  (REG_BASE),
        .REG_PATCH (REG_PATCH)
    ) u_match (
        .index (ioctl_index),
        .hit   (hit),
        .entry (entry),
        .base  (base),
        .patch (patch)
    );

    always_comb begin
        rise      = ioctl_download & ~dl_q;
        fall      = ~ioctl_download & dl_q;
        // A new download preempts a pending patch: the stream cannot be held off.
        start     = rise && (state != STREAM);
        in_stream = start || (state == STREAM && ioctl_download);
        // On the start cycle the latched entry is not yet valid; use the live match.
        cur_hit   = start ? hit : hit_q;
        cur_base  = start ? base : base_q;
        end_addr  = ioctl_addr + ADDR_W'(1);
        ptr       = PTR_BASE + 32'(length);
        k_last    = (k == 2'(PTR_BYTES - 1));
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rise) state_n = STREAM;
            STREAM:  if (fall) state_n = (hit_q && patch_q && length != '0) ? PATCH : FINISH;
            PATCH: begin
                if (rise)                          state_n = STREAM;
                else if (!gap && mem_ack && k_last) state_n = FINISH;
            end
            FINISH:  state_n = rise ? STREAM : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            hit_q       <= 1'b0;
            patch_q     <= 1'b0;
            ent_q       <= '0;
            base_q      <= '0;
            gap         <= 1'b0;
            k           <= '0;
            wr          <= 1'b0;
            addr        <= '0;
            data        <= '0;
            length      <= '0;
            unmapped    <= 1'b0;
            done        <= 1'b0;
            downloading <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            done <= 1'b0;
            if (start) begin
                hit_q       <= hit;
                patch_q     <= patch;
                ent_q       <= entry;
                base_q      <= base;
                unmapped    <= ~hit;
                downloading <= 1'b1;
            end
            if (in_stream) begin
                wr   <= ioctl_wr & cur_hit;
                addr <= cur_base + ioctl_addr;
                data <= ioctl_dout;
                if (ioctl_wr && (start || end_addr > length)) length <= end_addr;
                else if (start)                               length <= '0;
            end else begin
                case (state)
                    STREAM: begin
                        wr  <= 1'b0;
                        gap <= 1'b1;
                        k   <= '0;
                    end
                    PATCH: begin
                        // gap marks the single wr-low cycle before each pointer byte.
                        if (gap) begin
                            wr   <= 1'b1;
                            addr <= PATCH_ADDR + ADDR_W'(k);
                            data <= ptr[{k, 3'b000} +: 8];
                            gap  <= 1'b0;
                        end else if (mem_ack) begin
                            wr  <= 1'b0;
                            gap <= 1'b1;
                            k   <= k + 2'd1;
                        end
                    end
                    FINISH: begin
                        wr          <= 1'b0;
                        downloading <= 1'b0;
                        done        <= 1'b1;
                    end
                    default: wr <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_download_mapper.sv
// Directed and randomized downloads checked against a transaction-level model
// of the expected memory writes, length, unmapped and done behaviour.
module tb_download_mapper;

    localparam int AW = 25;
    localparam logic [7:0] M_MATCH [4] = '{8'h01, 8'h41, 8'h00, 8'h00};
    localparam logic [7:0] M_MASK  [4] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    localparam int         M_BASE  [4] = '{'h10995, 'h10995, 0, 0};
    localparam bit         M_PATCH [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam int         M_PADDR     = 'h103E9;
    localparam int         M_PTR       = 'h8995;

    logic          clk = 1'b0;
    logic          reset, ioctl_download, ioctl_wr, mem_ack;
    logic [7:0]    ioctl_index, ioctl_dout;
    logic [AW-1:0] ioctl_addr;
    logic          downloading, wr, unmapped, done;
    logic [AW-1:0] addr, length;
    logic [7:0]    data;

    always #5 clk = ~clk;

    download_mapper dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .mem_ack(mem_ack), .downloading(downloading),
        .wr(wr), .addr(addr), .data(data), .length(length),
        .unmapped(unmapped), .done(done)
    );

    int          n_chk = 0, n_err = 0;
    logic [32:0] got_q[$], exp_q[$];
    int          done_cnt = 0, last_gap = 0, last_burst = 0, gap_cnt = 0, burst = 0;
    logic        prev_wr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    bit          ack_rand = 1'b0;
    bit          cur_hit, cur_patch;
    int          cur_base, cur_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Collects distinct memory writes; a held write must keep addr/data stable.
    always @(posedge clk) begin
        #1;
        if (wr === 1'b1) begin
            if (!prev_wr) begin
                got_q.push_back({addr, data});
                last_gap = gap_cnt;
                burst    = 1;
            end else begin
                chk("hold", {addr, data}, {p_addr, p_data});
                burst++;
            end
            gap_cnt = 0;
        end else begin
            if (prev_wr) last_burst = burst;
            gap_cnt++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_dl_low", downloading, 0);
        end
        prev_wr = (wr === 1'b1);
        p_addr  = addr;
        p_data  = data;
    end

    function automatic void lookup(input logic [7:0] idx, output bit h, output int b, output bit p);
        h = 1'b0; b = 0; p = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!h && M_MASK[i] != 8'h00 && (idx & M_MASK[i]) == (M_MATCH[i] & M_MASK[i])) begin
                h = 1'b1; b = M_BASE[i]; p = M_PATCH[i];
            end
    endfunction

    task automatic tick();
        @(negedge clk);
        if (ack_rand) mem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic start_dl(input logic [7:0] idx);
        lookup(idx, cur_hit, cur_base, cur_patch);
        cur_len = 0;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
        chk("start_dl", downloading, 1);
        chk("start_unmapped", unmapped, !cur_hit);
        chk("start_len", length, 0);
    endtask

    task automatic send(input int off, input logic [7:0] dat);
        ioctl_addr = AW'(off);
        ioctl_dout = dat;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("wr_latency", wr, cur_hit);
        if (cur_hit) begin
            chk("wr_addr", addr, AW'(cur_base + off));
            chk("wr_data", data, dat);
            exp_q.push_back({AW'(cur_base + off), dat});
        end
        if (off + 1 > cur_len) cur_len = off + 1;
        chk("len_run", length, cur_len);
        tick();
        repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic finish_dl();
        int p;
        ioctl_download = 1'b0;
        if (cur_hit && cur_patch && cur_len != 0) begin
            p = (M_PTR + cur_len) & 'hFFFF;
            for (int b = 0; b < 2; b++)
                exp_q.push_back({AW'(M_PADDR + b), 8'(p >> (8 * b))});
        end
    endtask

    task automatic wait_done();
        int dc0 = done_cnt;
        int t = 0;
        while (done_cnt == dc0 && t < 300) begin
            tick();
            t++;
        end
        chk("done_seen", done_cnt - dc0, 1);
        chk("len_end", length, cur_len);
        chk("unmapped_end", unmapped, !cur_hit);
        tick();
        chk("done_once", done_cnt - dc0, 1);
        chk("dl_idle", downloading, 0);
    endtask

    task automatic compare_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_wr();
        int t = 0;
        while (wr !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("patch_wr_seen", wr, 1);
    endtask

    initial begin
        int dc0, n, hi;
        logic [7:0] idx;
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; mem_ack = 1'b1;
        repeat (3) tick();
        chk("rst_wr", wr, 0);          chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);      chk("rst_len", length, 0);
        chk("rst_unmapped", unmapped, 0); chk("rst_done", done, 0);
        chk("rst_dl", downloading, 0);
        reset = 1'b0;
        tick();

        // ROM: four bytes, no patch
        start_dl(8'h00);
        for (int i = 0; i < 4; i++) send(i, 8'($urandom));
        finish_dl();
        wait_done();
        compare_q("rom");

        // PRG: sixteen bytes then two pointer bytes separated by one idle cycle
        start_dl(8'h01);
        for (int i = 0; i < 16; i++) send(i, 8'($urandom));
        finish_dl();
        wait_done();
        chk("prg_gap", last_gap, 1);
        compare_q("prg");

        // Ack stall on pointer byte 0, then on byte 1
        start_dl(8'h01);
        for (int i = 0; i < 16; i++) send(i, 8'($urandom));
        mem_ack = 1'b0;
        finish_dl();
        wait_wr();
        repeat (3) tick();
        mem_ack = 1'b1;
        tick();
        chk("stall_burst", last_burst, 4);
        mem_ack = 1'b0;
        dc0 = done_cnt;
        repeat (3) tick();
        chk("stall_no_done", done_cnt, dc0);
        chk("stall_byte1_held", {wr, addr}, {1'b1, AW'(M_PADDR + 1)});
        mem_ack = 1'b1;
        wait_done();
        compare_q("stall");

        // Unmapped index
        start_dl(8'h07);
        for (int i = 0; i < 3; i++) send(i, 8'($urandom));
        finish_dl();
        wait_done();
        compare_q("unmapped");

        // Abort: new download arrives in the idle cycle between pointer bytes
        start_dl(8'h41);
        for (int i = 0; i < 8; i++) send(i, 8'($urandom));
        mem_ack = 1'b0;
        ioctl_download = 1'b0;
        exp_q.push_back({AW'(M_PADDR), 8'((M_PTR + cur_len) & 'hFF)});
        wait_wr();
        mem_ack = 1'b1;
        tick();
        chk("abort_gap", wr, 0);
        mem_ack = 1'b0;
        dc0 = done_cnt;
        start_dl(8'h00);
        chk("abort_no_done", done_cnt, dc0);
        for (int i = 0; i < 5; i++) send(i, 8'($urandom));
        finish_dl();
        wait_done();
        compare_q("abort");

        // Reset in the middle of a stream with download still high
        mem_ack = 1'b1;
        start_dl(8'h01);
        for (int i = 0; i < 5; i++) send(i, 8'($urandom));
        compare_q("pre_reset");
        ioctl_addr = AW'(5); ioctl_dout = 8'h5A; ioctl_wr = 1'b1; reset = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        chk("mid_rst_outs", {wr, addr, data, length, unmapped, done, downloading}, '0);
        reset = 1'b0;
        lookup(8'h01, cur_hit, cur_base, cur_patch);
        cur_len = 0;
        tick();
        chk("restart_dl", downloading, 1);
        chk("restart_len", length, 0);
        for (int i = 0; i < 3; i++) send(i, 8'($urandom));
        finish_dl();
        wait_done();
        compare_q("restart");

        // Randomized downloads with random ack pacing, including address wrap
        ack_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 4))
                0: idx = 8'h00;
                1: idx = 8'h01;
                2: idx = 8'h41;
                3: idx = 8'h07;
                default: idx = 8'($urandom);
            endcase
            n  = $urandom_range(1, 12);
            hi = ($urandom_range(0, 3) == 0) ? 'h1FFFF00 : 0;
            start_dl(idx);
            for (int i = 0; i < n; i++) send(hi + $urandom_range(0, 30), 8'($urandom));
            finish_dl();
            wait_done();
            compare_q("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
